// File: rtl/fifo_check_pkg.sv
// fifo_check_pkg: error-bit map, error vector type and saturating increment for fifo_checker
package fifo_check_pkg;
    localparam int ERR_DATA   = 0;
    localparam int ERR_WRACK  = 1;
    localparam int ERR_OVF    = 2;
    localparam int ERR_UDF    = 3;
    localparam int ERR_FULL   = 4;
    localparam int ERR_EMPTY  = 5;
    localparam int ERR_AFULL  = 6;
    localparam int ERR_AEMPTY = 7;
    typedef logic [7:0] fifo_err_t;
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] max;
        max = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v == max) ? v : v + 32'd1;
    endfunction
endpackage

// File: rtl/fifo_checker_ref.sv
// fifo_checker_ref: shadow FIFO model producing expected flags, handshakes and read data
module fifo_checker_ref import fifo_check_pkg::*; #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] data_in,
    output logic             full_exp,
    output logic             empty_exp,
    output logic             afull_exp,
    output logic             aempty_exp,
    output logic             wr_ack_exp,
    output logic             ovf_exp,
    output logic             udf_exp,
    output logic             data_vld,
    output logic [WIDTH-1:0] data_exp
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_cnt;
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic             r_wr_ack;
    logic             r_ovf;
    logic             r_udf;
    logic             r_data_vld;
    logic [WIDTH-1:0] r_data;
    logic             w_wr_acc;
    logic             w_rd_acc;

    // acceptance depends only on the shadow count, so DUT flag bugs cannot mask themselves
    assign full_exp   = r_cnt == CW'(DEPTH);
    assign empty_exp  = r_cnt == '0;
    assign afull_exp  = r_cnt == CW'(DEPTH - 1);
    assign aempty_exp = r_cnt == CW'(1);
    assign w_wr_acc   = wr_en && !full_exp;
    assign w_rd_acc   = rd_en && !empty_exp;
    assign wr_ack_exp = r_wr_ack;
    assign ovf_exp    = r_ovf;
    assign udf_exp    = r_udf;
    assign data_vld   = r_data_vld;
    assign data_exp   = r_data;

    // shadow state and the expected registered outputs, compared one edge later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_wr_ack   <= 1'b0;
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
            r_data_vld <= 1'b0;
            r_data     <= '0;
        end else begin
            r_wptr     <= w_wr_acc ? ((r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1) : r_wptr;
            r_rptr     <= w_rd_acc ? ((r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1) : r_rptr;
            r_cnt      <= r_cnt + CW'(w_wr_acc) - CW'(w_rd_acc);
            r_wr_ack   <= w_wr_acc;
            r_ovf      <= wr_en && !w_wr_acc;
            r_udf      <= rd_en && !w_rd_acc;
            r_data_vld <= w_rd_acc;
            r_data     <= w_rd_acc ? r_mem[r_rptr] : r_data;
        end
    end

    // shadow data storage; contents are meaningless until written, so no reset
    always_ff @(posedge clk) begin
        if (w_wr_acc) r_mem[r_wptr] <= data_in;
    end
endmodule

// File: rtl/fifo_checker.sv
// fifo_checker: compares a FIFO's pins against a shadow model and keeps error statistics
module fifo_checker import fifo_check_pkg::*; #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             chk_en,
    input  logic             clear_counts,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] data_out,
    input  logic             wr_ack,
    input  logic             overflow,
    input  logic             underflow,
    input  logic             full,
    input  logic             empty,
    input  logic             almostfull,
    input  logic             almostempty,
    output logic [7:0]       err_pulse,
    output logic [7:0]       err_sticky,
    output logic [CNT_W-1:0] correct_count,
    output logic [CNT_W-1:0] error_count,
    output logic             first_err_valid,
    output logic [7:0]       first_err_flags
);
    logic             w_full_exp;
    logic             w_empty_exp;
    logic             w_afull_exp;
    logic             w_aempty_exp;
    logic             w_wr_ack_exp;
    logic             w_ovf_exp;
    logic             w_udf_exp;
    logic             w_data_vld;
    logic [WIDTH-1:0] w_data_exp;
    fifo_err_t        w_err;
    fifo_err_t        r_err_pulse;
    fifo_err_t        r_err_sticky;
    logic [CNT_W-1:0] r_correct;
    logic [CNT_W-1:0] r_error;
    logic             r_first_valid;
    fifo_err_t        r_first_flags;

    fifo_checker_ref #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ref (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .data_in    (data_in),
        .full_exp   (w_full_exp),
        .empty_exp  (w_empty_exp),
        .afull_exp  (w_afull_exp),
        .aempty_exp (w_aempty_exp),
        .wr_ack_exp (w_wr_ack_exp),
        .ovf_exp    (w_ovf_exp),
        .udf_exp    (w_udf_exp),
        .data_vld   (w_data_vld),
        .data_exp   (w_data_exp)
    );

    // per-check mismatch vector for the current edge
    always_comb begin
        w_err             = '0;
        w_err[ERR_DATA]   = w_data_vld && (data_out != w_data_exp);
        w_err[ERR_WRACK]  = wr_ack != w_wr_ack_exp;
        w_err[ERR_OVF]    = overflow != w_ovf_exp;
        w_err[ERR_UDF]    = underflow != w_udf_exp;
        w_err[ERR_FULL]   = full != w_full_exp;
        w_err[ERR_EMPTY]  = empty != w_empty_exp;
        w_err[ERR_AFULL]  = almostfull != w_afull_exp;
        w_err[ERR_AEMPTY] = almostempty != w_aempty_exp;
    end

    // pulse, sticky, saturating counters and first-error capture; clear beats any update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_pulse   <= '0;
            r_err_sticky  <= '0;
            r_correct     <= '0;
            r_error       <= '0;
            r_first_valid <= 1'b0;
            r_first_flags <= '0;
        end else begin
            r_err_pulse <= chk_en ? w_err : '0;
            if (clear_counts) begin
                r_err_sticky  <= '0;
                r_correct     <= '0;
                r_error       <= '0;
                r_first_valid <= 1'b0;
                r_first_flags <= '0;
            end else if (chk_en) begin
                r_err_sticky <= r_err_sticky | w_err;
                r_correct    <= (w_err == '0) ? CNT_W'(sat_inc(32'(r_correct), CNT_W)) : r_correct;
                r_error      <= (w_err != '0) ? CNT_W'(sat_inc(32'(r_error), CNT_W)) : r_error;
                if (!r_first_valid && w_err != '0) begin
                    r_first_valid <= 1'b1;
                    r_first_flags <= w_err;
                end
            end
        end
    end

    assign err_pulse       = r_err_pulse;
    assign err_sticky      = r_err_sticky;
    assign correct_count   = r_correct;
    assign error_count     = r_error;
    assign first_err_valid = r_first_valid;
    assign first_err_flags = r_first_flags;
endmodule

// File: tb/tb_fifo_checker.sv
// tb_fifo_checker: directed scenarios against a behavioural FIFO with fault knobs
module tb_fifo_checker;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        chk_en = 1'b1;
    logic        clear_counts = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [15:0] data_in = '0;
    logic [15:0] data_out;
    logic        wr_ack, overflow, underflow, full, empty, almostfull, almostempty;
    logic        no_ovf = 1'b0;
    logic        corrupt = 1'b0;
    logic        flip_empty = 1'b0;
    logic [15:0] f_mem [8];
    logic [3:0]  f_cnt;
    logic [2:0]  f_wp, f_rp;
    logic [15:0] f_dout;
    logic        f_full, f_empty, f_wacc, f_racc;
    logic [7:0]  d_pulse, d_sticky, d_first_flags, s_pulse, s_sticky, s_first_flags;
    logic [15:0] d_correct, d_error;
    logic [3:0]  s_correct, s_error;
    logic        d_first_valid, s_first_valid;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    // behavioural FIFO: registered handshakes/data, combinational flags
    assign f_full      = f_cnt == 4'd8;
    assign f_empty     = f_cnt == 4'd0;
    assign f_wacc      = wr_en && !f_full;
    assign f_racc      = rd_en && !f_empty;
    assign full        = f_full;
    assign empty       = f_empty ^ flip_empty;
    assign almostfull  = f_cnt == 4'd7;
    assign almostempty = f_cnt == 4'd1;
    assign data_out    = corrupt ? (f_dout ^ 16'h0001) : f_dout;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_cnt <= '0; f_wp <= '0; f_rp <= '0; f_dout <= '0;
            wr_ack <= 1'b0; overflow <= 1'b0; underflow <= 1'b0;
        end else begin
            wr_ack    <= f_wacc;
            overflow  <= wr_en && f_full && !no_ovf;
            underflow <= rd_en && f_empty;
            if (f_wacc) begin f_mem[f_wp] <= data_in; f_wp <= f_wp + 3'd1; end
            if (f_racc) begin f_dout <= f_mem[f_rp]; f_rp <= f_rp + 3'd1; end
            f_cnt <= f_cnt + 4'(f_wacc) - 4'(f_racc);
        end
    end

    fifo_checker u_dut (
        .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .clear_counts(clear_counts),
        .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in), .data_out(data_out),
        .wr_ack(wr_ack), .overflow(overflow), .underflow(underflow),
        .full(full), .empty(empty), .almostfull(almostfull), .almostempty(almostempty),
        .err_pulse(d_pulse), .err_sticky(d_sticky), .correct_count(d_correct),
        .error_count(d_error), .first_err_valid(d_first_valid), .first_err_flags(d_first_flags)
    );

    fifo_checker #(.CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .clear_counts(clear_counts),
        .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in), .data_out(data_out),
        .wr_ack(wr_ack), .overflow(overflow), .underflow(underflow),
        .full(full), .empty(empty), .almostfull(almostfull), .almostempty(almostempty),
        .err_pulse(s_pulse), .err_sticky(s_sticky), .correct_count(s_correct),
        .error_count(s_error), .first_err_valid(s_first_valid), .first_err_flags(s_first_flags)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_step();
        clear_counts = 1'b1;
        step();
        clear_counts = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (d_pulse !== 8'h00) begin failures++; $display("FAIL reset_pulse got=%h exp=00", d_pulse); end
        checks++; if (d_sticky !== 8'h00) begin failures++; $display("FAIL reset_sticky got=%h exp=00", d_sticky); end
        checks++; if (d_correct !== 16'd0 || d_error !== 16'd0) begin failures++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", d_correct, d_error); end
        checks++; if (d_first_valid !== 1'b0 || d_first_flags !== 8'h00) begin failures++; $display("FAIL reset_first got=%b/%h exp=0/00", d_first_valid, d_first_flags); end
        step();
        rst_n = 1'b1;
        step();
        checks++; if (d_pulse !== 8'h00) begin failures++; $display("FAIL first_edge_pulse got=%h exp=00", d_pulse); end
        checks++; if (d_correct !== 16'd1) begin failures++; $display("FAIL first_edge_correct got=%0d exp=1", d_correct); end
    endtask

    task automatic test_fill();
        clear_step();
        checks++; if (d_correct !== 16'd0) begin failures++; $display("FAIL fill_clear got=%0d exp=0", d_correct); end
        for (int i = 1; i <= 8; i++) begin
            wr_en = 1'b1;
            data_in = 16'(i);
            step();
            checks++; if (d_pulse !== 8'h00) begin failures++; $display("FAIL fill_pulse_%0d got=%h exp=00", i, d_pulse); end
            if (i == 7) begin
                checks++; if (u_dut.w_afull_exp !== 1'b1) begin failures++; $display("FAIL fill_afull got=%b exp=1", u_dut.w_afull_exp); end
            end
        end
        wr_en = 1'b0;
        checks++; if (u_dut.w_full_exp !== 1'b1) begin failures++; $display("FAIL fill_full got=%b exp=1", u_dut.w_full_exp); end
        checks++; if (d_correct !== 16'd8 || d_error !== 16'd0) begin failures++; $display("FAIL fill_counts got=%0d/%0d exp=8/0", d_correct, d_error); end
    endtask

    task automatic test_overflow();
        no_ovf = 1'b1;
        wr_en = 1'b1;
        data_in = 16'hDEAD;
        step();
        no_ovf = 1'b0;
        wr_en = 1'b0;
        checks++; if (d_pulse !== 8'h00) begin failures++; $display("FAIL ovf_before got=%h exp=00", d_pulse); end
        step();
        checks++; if (d_pulse !== 8'h04) begin failures++; $display("FAIL ovf_pulse got=%h exp=04", d_pulse); end
        checks++; if (d_sticky[2] !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%h exp=bit2", d_sticky); end
        checks++; if (d_error !== 16'd1) begin failures++; $display("FAIL ovf_error_count got=%0d exp=1", d_error); end
        checks++; if (d_first_valid !== 1'b1 || d_first_flags !== 8'h04) begin failures++; $display("FAIL ovf_first got=%b/%h exp=1/04", d_first_valid, d_first_flags); end
        step();
        checks++; if (d_pulse !== 8'h00) begin failures++; $display("FAIL ovf_after got=%h exp=00", d_pulse); end
        checks++; if (d_correct !== 16'd10) begin failures++; $display("FAIL ovf_correct got=%0d exp=10", d_correct); end
    endtask

    task automatic test_data();
        clear_step();
        checks++; if (d_sticky !== 8'h00 || d_first_valid !== 1'b0) begin failures++; $display("FAIL data_clear got=%h/%b exp=00/0", d_sticky, d_first_valid); end
        for (int i = 0; i < 8; i++) begin
            rd_en = 1'b1;
            step();
            checks++; if (d_pulse !== 8'h00) begin failures++; $display("FAIL drain_pulse_%0d got=%h exp=00", i, d_pulse); end
        end
        rd_en = 1'b0;
        wr_en = 1'b1;
        data_in = 16'hA5A5;
        step();
        checks++; if (d_pulse !== 8'h00) begin failures++; $display("FAIL data_write got=%h exp=00", d_pulse); end
        wr_en = 1'b0;
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        checks++; if (d_pulse !== 8'h00) begin failures++; $display("FAIL data_read_edge got=%h exp=00", d_pulse); end
        corrupt = 1'b1;
        step();
        corrupt = 1'b0;
        checks++; if (d_pulse !== 8'h01) begin failures++; $display("FAIL data_pulse got=%h exp=01", d_pulse); end
        checks++; if (d_error !== 16'd1 || d_first_flags !== 8'h01) begin failures++; $display("FAIL data_capture got=%0d/%h exp=1/01", d_error, d_first_flags); end
    endtask

    task automatic test_simul_wrap();
        clear_step();
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1;
            data_in = 16'(16'h0100 + i);
            step();
            checks++; if (d_pulse !== 8'h00) begin failures++; $display("FAIL simul_prefill_%0d got=%h exp=00", i, d_pulse); end
        end
        for (int i = 0; i < 20; i++) begin
            wr_en = 1'b1;
            rd_en = 1'b1;
            data_in = 16'(16'h0200 + i);
            step();
            checks++; if (d_pulse !== 8'h00) begin failures++; $display("FAIL simul_pulse_%0d got=%h exp=00", i, d_pulse); end
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        step();
        checks++; if (d_pulse !== 8'h00) begin failures++; $display("FAIL simul_last got=%h exp=00", d_pulse); end
        checks++; if (u_dut.u_ref.r_cnt !== 4'd3) begin failures++; $display("FAIL simul_count got=%0d exp=3", u_dut.u_ref.r_cnt); end
        checks++; if (u_dut.u_ref.r_wptr !== 3'd0 || u_dut.u_ref.r_rptr !== 3'd5) begin failures++; $display("FAIL simul_ptrs got=%0d/%0d exp=0/5", u_dut.u_ref.r_wptr, u_dut.u_ref.r_rptr); end
        checks++; if (d_correct !== 16'd24 || d_error !== 16'd0) begin failures++; $display("FAIL simul_counts got=%0d/%0d exp=24/0", d_correct, d_error); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1;
            data_in = 16'(16'h0300 + i);
            step();
        end
        wr_en = 1'b0;
        flip_empty = 1'b1;
        step();
        flip_empty = 1'b0;
        checks++; if (d_pulse !== 8'h20) begin failures++; $display("FAIL mid_pre_pulse got=%h exp=20", d_pulse); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (d_pulse !== 8'h00 || d_sticky !== 8'h00) begin failures++; $display("FAIL mid_async_bits got=%h/%h exp=00/00", d_pulse, d_sticky); end
        checks++; if (d_correct !== 16'd0 || d_error !== 16'd0) begin failures++; $display("FAIL mid_async_counts got=%0d/%0d exp=0/0", d_correct, d_error); end
        checks++; if (d_first_valid !== 1'b0 || d_first_flags !== 8'h00) begin failures++; $display("FAIL mid_async_first got=%b/%h exp=0/00", d_first_valid, d_first_flags); end
        checks++; if (u_dut.u_ref.r_cnt !== 4'd0) begin failures++; $display("FAIL mid_shadow_count got=%0d exp=0", u_dut.u_ref.r_cnt); end
        step();
        rst_n = 1'b1;
        step();
        checks++; if (d_pulse !== 8'h00) begin failures++; $display("FAIL mid_release_pulse got=%h exp=00", d_pulse); end
        checks++; if (d_correct !== 16'd1 || d_error !== 16'd0) begin failures++; $display("FAIL mid_release_counts got=%0d/%0d exp=1/0", d_correct, d_error); end
    endtask

    task automatic test_chk_disable();
        chk_en = 1'b0;
        flip_empty = 1'b1;
        step();
        flip_empty = 1'b0;
        chk_en = 1'b1;
        checks++; if (d_pulse !== 8'h00 || d_sticky !== 8'h00) begin failures++; $display("FAIL dis_bits got=%h/%h exp=00/00", d_pulse, d_sticky); end
        checks++; if (d_correct !== 16'd1 || d_error !== 16'd0) begin failures++; $display("FAIL dis_counts got=%0d/%0d exp=1/0", d_correct, d_error); end
    endtask

    task automatic test_saturation();
        clear_step();
        for (int i = 0; i < 20; i++) step();
        checks++; if (s_correct !== 4'd15 || s_error !== 4'd0) begin failures++; $display("FAIL sat_counts got=%0d/%0d exp=15/0", s_correct, s_error); end
        checks++; if (d_correct !== 16'd20) begin failures++; $display("FAIL sat_wide_count got=%0d exp=20", d_correct); end
        flip_empty = 1'b1;
        step();
        flip_empty = 1'b0;
        checks++; if (s_pulse !== 8'h20) begin failures++; $display("FAIL sat_err_pulse got=%h exp=20", s_pulse); end
        checks++; if (s_first_valid !== 1'b1 || s_first_flags !== 8'h20 || s_error !== 4'd1) begin failures++; $display("FAIL sat_first got=%b/%h/%0d exp=1/20/1", s_first_valid, s_first_flags, s_error); end
        checks++; if (s_correct !== 4'd15) begin failures++; $display("FAIL sat_hold got=%0d exp=15", s_correct); end
        clear_step();
        checks++; if (s_correct !== 4'd0 || s_error !== 4'd0) begin failures++; $display("FAIL sat_clear_counts got=%0d/%0d exp=0/0", s_correct, s_error); end
        checks++; if (s_first_valid !== 1'b0 || s_first_flags !== 8'h00 || s_sticky !== 8'h00) begin failures++; $display("FAIL sat_clear_first got=%b/%h/%h exp=0/00/00", s_first_valid, s_first_flags, s_sticky); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_data();
        test_simul_wrap();
        test_reset_mid();
        test_chk_disable();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
